// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO between a host and a UART transmitter. The host pushes
//             bytes with wr_en. The head byte is presented show-ahead on
//             tx_din/tx_valid. It is popped on each tx_valid & tx_ready
//             handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH        entry count (power of two, >= 2)
//    AF_LEVEL     occupancy at or above which almost_full asserts
//  Ports
//    clk          single clock, rising edge
//    rst          asynchronous reset, active low
//    wr_data[7:0] byte pushed by the host
//    wr_en        push strobe, one byte per cycle
//    flush        synchronous discard of all stored bytes
//    full         occupancy == DEPTH
//    almost_full  occupancy >= AF_LEVEL
//    count        current occupancy, clog2(DEPTH)+1 bits
//    tx_din[7:0]  head byte to the transmitter
//    tx_valid     head byte valid; drives the transmitter send enable
//    tx_ready     transmitter idle / ready to accept
//    overflow     sticky flag: a push was rejected while full
//    ovf_clr      synchronous clear of overflow
//  Configuration
//    UART_TX_FIFO_OVF_EN  when defined, overflow records rejected pushes;
//                         otherwise overflow is tied low and ovf_clr ignored.
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              wr_data,
   input  logic                    wr_en,
   input  logic                    flush,
   output logic                    full,
   output logic                    almost_full,
   output logic [$clog2(DEPTH):0]  count,
   output logic [7:0]              tx_din,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    overflow,
   input  logic                    ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;

   // All status flags decode from the registered count only, so there is no
   // combinational path from wr_en or tx_ready to any output.
   assign count       = count_q;
   assign tx_valid    = (count_q != '0);
   assign full        = (count_q == FULL_LEVEL);
   assign almost_full = (count_q >= AF_COUNT);

   // Show-ahead head entry, read straight from the registered read pointer.
   assign tx_din = mem[rd_ptr];

   // A push while full is rejected outright; a pop in the same cycle does
   // not make room for it because full reflects the pre-edge occupancy.
   assign push = wr_en && !full;
   assign pop  = tx_valid && tx_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is deliberately not reset; its contents are only observable
   // through tx_din once count says the head entry is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

`ifdef UART_TX_FIFO_OVF_EN
   logic reject;
   logic overflow_q;

   // A push ignored because of flush is not a rejection.
   assign reject = wr_en && full && !flush;

   // A rejection in the same cycle as ovf_clr wins, so no event is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else if (reject) begin
         overflow_q <= 1'b1;
      end else if (ovf_clr) begin
         overflow_q <= 1'b0;
      end
   end

   assign overflow = overflow_q;
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = ovf_clr;
   assign overflow       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. A queue-based model holds
//             the expected contents. A negedge monitor compares the DUT
//             state and every popped byte against that model. A serial
//             UART transmitter/receiver pair checks the bytes on the line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;
   localparam int BP       = 4;   // clocks per serial bit
`ifdef UART_TX_FIFO_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [7:0]             wr_data;
   logic                   wr_en;
   logic                   flush;
   logic                   full;
   logic                   almost_full;
   logic [$clog2(DEPTH):0] count;
   logic [7:0]             tx_din;
   logic                   tx_valid;
   logic                   tx_ready;
   logic                   overflow;
   logic                   ovf_clr;

   logic                   uart_mode    = 1'b0;
   logic                   manual_ready = 1'b0;
   logic                   uart_busy    = 1'b0;
   logic                   line         = 1'b1;
   logic [9:0]             tx_sh;
   int                     bit_i;
   int                     clk_i;

   int                     tests = 0;
   int                     fails = 0;

   logic [7:0]             model_q[$];
   logic [7:0]             line_q[$];
   logic                   ovf_model = 1'b0;
   logic [7:0]             last_pop  = 8'h00;
   int                     sz;

   uart_tx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .flush       (flush),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .tx_din      (tx_din),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   assign tx_ready = uart_mode ? !uart_busy : manual_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference model (negedge) ----------------
   always @(negedge clk) begin
      if (!rst) begin
         model_q.delete();
         ovf_model = 1'b0;
         check("rst_count", 32'(count), 0);
         check("rst_tx_valid", 32'(tx_valid), 0);
         check("rst_full", 32'(full), 0);
         check("rst_almost_full", 32'(almost_full), 0);
         check("rst_overflow", 32'(overflow), 0);
      end else begin
         sz = model_q.size();
         check("count", 32'(count), 32'(sz));
         check("tx_valid", 32'(tx_valid), 32'(sz != 0));
         check("full", 32'(full), 32'(sz == DEPTH));
         check("almost_full", 32'(almost_full), 32'(sz >= AF_LEVEL));
         check("overflow", 32'(overflow), 32'(ovf_model));
         if (sz != 0) check("tx_din", 32'(tx_din), 32'(model_q[0]));
         // Predict what the coming rising edge does.
         if (flush) begin
            model_q.delete();
            if (ovf_clr) ovf_model = 1'b0;
         end else begin
            if (sz != 0 && tx_ready) last_pop = model_q.pop_front();
            if (wr_en && sz < DEPTH) model_q.push_back(wr_data);
            if (wr_en && sz == DEPTH) ovf_model = OVF_EN;
            else if (ovf_clr) ovf_model = 1'b0;
         end
      end
   end

   // ---------------- UART transmitter model ----------------
   always @(posedge clk) begin
      if (!uart_busy) begin
         if (uart_mode && tx_valid) begin
            tx_sh     <= {1'b1, tx_din, 1'b0};
            uart_busy <= 1'b1;
            line      <= 1'b0;
            bit_i     <= 0;
            clk_i     <= 0;
         end
      end else if (clk_i == BP - 1) begin
         clk_i <= 0;
         if (bit_i == 9) begin
            uart_busy <= 1'b0;
         end else begin
            bit_i <= bit_i + 1;
            line  <= tx_sh[bit_i + 1];
         end
      end else begin
         clk_i <= clk_i + 1;
      end
   end

   // ---------------- serial line receiver ----------------
   initial begin
      logic [7:0] rb;
      forever begin
         @(negedge clk);
         if (uart_mode && line == 1'b0) begin
            repeat (BP / 2) @(negedge clk);
            check("rx_start", 32'(line), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (BP) @(negedge clk);
               rb[i] = line;
            end
            repeat (BP) @(negedge clk);
            check("rx_stop", 32'(line), 1);
            if (line_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rx_unexpected: got byte 0x%0h, expected none", rb);
            end else begin
               check("rx_byte", 32'(rb), 32'(line_q.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic we, input logic [7:0] d, input logic rdy);
      wr_en        = we;
      wr_data      = d;
      manual_ready = rdy;
      @(posedge clk);
      #1;
      wr_en        = 1'b0;
      manual_ready = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (count != 0 && n < 4 * DEPTH) begin
         cyc(1'b0, 8'h00, 1'b1);
         n++;
      end
      check("drain_done", 32'(count), 0);
   endtask

   initial begin
      int sent;
      int guard;
      logic [7:0] b;
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      flush   = 1'b0;
      ovf_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_count", 32'(count), 0);
      check("reset_tx_valid", 32'(tx_valid), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single byte, one-cycle latency, single pop per handshake.
      cyc(1'b1, 8'h55, 1'b0);
      check("lat_tx_valid", 32'(tx_valid), 1);
      check("lat_tx_din", 32'(tx_din), 32'h55);
      check("lat_count", 32'(count), 1);
      cyc(1'b0, 8'h00, 1'b1);
      check("pop_count", 32'(count), 0);
      check("pop_tx_valid", 32'(tx_valid), 0);

      // Fill to full, almost_full threshold, rejected push, overflow clear.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         check("fill_almost_full", 32'(almost_full), 32'((i + 1) >= AF_LEVEL));
         check("fill_full", 32'(full), 32'(i == DEPTH - 1));
      end
      cyc(1'b1, 8'hAA, 1'b0);
      check("reject_count", 32'(count), 32'(DEPTH));
      check("reject_overflow", 32'(overflow), 32'(OVF_EN));
      ovf_clr = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 0);

      // Push while full together with a pop: pop happens, push is rejected.
      cyc(1'b1, 8'hBB, 1'b1);
      check("full_pushpop_count", 32'(count), 32'(DEPTH - 1));
      check("full_pushpop_head", 32'(last_pop), 32'h00);
      drain();

      // Simultaneous push and pop at count 5, FIFO order to the end.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0);
      cyc(1'b1, 8'h11, 1'b1);
      check("pushpop_count", 32'(count), 5);
      drain();
      check("order_last", 32'(last_pop), 32'h11);

      // Flush discards contents and ignores a concurrent push/pop.
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 1'b0);
      flush = 1'b1;
      cyc(1'b1, 8'h77, 1'b1);
      flush = 1'b0;
      check("flush_count", 32'(count), 0);
      check("flush_tx_valid", 32'(tx_valid), 0);
      cyc(1'b1, 8'h42, 1'b0);
      check("post_flush_din", 32'(tx_din), 32'h42);
      drain();

      // Randomised traffic; the monitor checks every cycle.
      for (int i = 0; i < 400; i++) begin
         flush   = ($urandom_range(0, 49) == 0);
         ovf_clr = ($urandom_range(0, 19) == 0);
         cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3);
      end
      flush   = 1'b0;
      ovf_clr = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      ovf_clr = 1'b0;
      drain();

      // 40 bytes through the FIFO to a serial transmitter (pointer wrap).
      uart_mode = 1'b1;
      sent  = 0;
      guard = 0;
      while (sent < 40 && guard < 5000) begin
         if (!full) begin
            b       = 8'($urandom);
            line_q.push_back(b);
            wr_en   = 1'b1;
            wr_data = b;
            sent++;
         end
         @(posedge clk);
         #1;
         wr_en = 1'b0;
         guard++;
      end
      guard = 0;
      while ((line_q.size() != 0 || uart_busy || count != 0) && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("uart_sent", 32'(sent), 40);
      check("uart_line_done", 32'(line_q.size()), 0);
      uart_mode = 1'b0;

      // Reset in the middle of a stream.
      for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < DEPTH - 7; i++) cyc(1'b0, 8'h00, 1'b1);
      check("pre_rst_count", 32'(count), 7);
      rst = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 0);
      check("async_rst_tx_valid", 32'(tx_valid), 0);
      check("async_rst_overflow", 32'(overflow), 0);
      check("async_rst_full", 32'(full), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 8'h3C, 1'b0);
      check("post_rst_din", 32'(tx_din), 32'h3C);
      check("post_rst_count", 32'(count), 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
